// File: rtl/id_stage_if.sv
// Pipeline-side bundle of the decode stage: fetch inputs, EX/MEM/WB hazard and
// writeback inputs, the fetch redirect/stall outputs and the ID/EX register outputs.
// The slave modport is the decode stage itself; master is the surrounding pipeline.
interface id_stage_if #(
    parameter int WORD_LENGTH = 32,
    parameter int IDX_W       = 5
);
    logic [WORD_LENGTH-1:0] PCAdder1In;
    logic [WORD_LENGTH-1:0] InstIn;
    logic                   exMemRead;
    logic                   exRegWrite;
    logic [IDX_W-1:0]       exDest;
    logic                   memRegWrite;
    logic [IDX_W-1:0]       memDest;
    logic                   wbRegWrite;
    logic [IDX_W-1:0]       wbDest;
    logic [WORD_LENGTH-1:0] wbData;

    logic                   pcEnb;
    logic                   BranchTaken;
    logic [WORD_LENGTH-1:0] BranchAddress;
    logic                   idExValid;
    logic                   idExRegWrite;
    logic                   idExMemRead;
    logic                   idExMemWrite;
    logic                   idExAluSrc;
    logic [2:0]             idExAluOp;
    logic [WORD_LENGTH-1:0] idExRsData;
    logic [WORD_LENGTH-1:0] idExRtData;
    logic [WORD_LENGTH-1:0] idExImm;
    logic [IDX_W-1:0]       idExRs;
    logic [IDX_W-1:0]       idExRt;
    logic [IDX_W-1:0]       idExDest;
    logic [31:0]            stallCount;

    modport slave (
        input  PCAdder1In, InstIn, exMemRead, exRegWrite, exDest,
               memRegWrite, memDest, wbRegWrite, wbDest, wbData,
        output pcEnb, BranchTaken, BranchAddress, idExValid, idExRegWrite,
               idExMemRead, idExMemWrite, idExAluSrc, idExAluOp, idExRsData,
               idExRtData, idExImm, idExRs, idExRt, idExDest, stallCount
    );

    modport master (
        output PCAdder1In, InstIn, exMemRead, exRegWrite, exDest,
               memRegWrite, memDest, wbRegWrite, wbDest, wbData,
        input  pcEnb, BranchTaken, BranchAddress, idExValid, idExRegWrite,
               idExMemRead, idExMemWrite, idExAluSrc, idExAluOp, idExRsData,
               idExRtData, idExImm, idExRs, idExRt, idExDest, stallCount
    );
endinterface

// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID register, 32x32 register file with WB bypass,
// branch/jump resolution back to fetch, load-use and branch-operand stall
// detection, and the ID/EX register.
// Optional feature: define ID_STALL_COUNTER_EN to count stall cycles on
// stallCount; otherwise stallCount is tied to zero.
// Instructions the decoder does not recognise, and all branches/jumps, enter
// ID/EX as valid entries with every control bit clear.
module id_stage #(
    parameter int WORD_LENGTH = 32,
    parameter int REG_COUNT   = 32
) (
    input logic     clk,
    input logic     rst,
    id_stage_if.slave bus
);
    localparam int IDX_W = $clog2(REG_COUNT);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    logic                   ifid_valid;
    logic [WORD_LENGTH-1:0] ifid_pc4;
    logic [31:0]            ifid_instr;
    logic [WORD_LENGTH-1:0] regs [REG_COUNT];

    logic [5:0]             opcode;
    logic [5:0]             funct;
    logic [IDX_W-1:0]       rs;
    logic [IDX_W-1:0]       rt;
    logic [IDX_W-1:0]       rd;
    logic [15:0]            imm16;
    logic [WORD_LENGTH-1:0] imm_ext;

    logic                   reg_write, mem_read, mem_write, alu_src;
    logic [2:0]             alu_op;
    logic [IDX_W-1:0]       dest;
    logic                   uses_rs, uses_rt, is_beq, is_bne, is_j;

    logic [WORD_LENGTH-1:0] rs_data, rt_data;
    logic                   load_use, branch_hazard, stall, branch_taken;

    assign opcode  = ifid_instr[31:26];
    assign rs      = ifid_instr[25:21];
    assign rt      = ifid_instr[20:16];
    assign rd      = ifid_instr[15:11];
    assign funct   = ifid_instr[5:0];
    assign imm16   = ifid_instr[15:0];
    assign imm_ext = {{(WORD_LENGTH-16){imm16[15]}}, imm16};

    // Decode the IF/ID instruction into ID/EX controls and the set of sources it reads.
    always_comb begin
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        alu_src   = 1'b0;
        alu_op    = ALU_ADD;
        dest      = '0;
        uses_rs   = 1'b0;
        uses_rt   = 1'b0;
        is_beq    = 1'b0;
        is_bne    = 1'b0;
        is_j      = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                reg_write = 1'b1;
                uses_rs   = 1'b1;
                uses_rt   = 1'b1;
                dest      = rd;
                case (funct)
                    6'h20:   alu_op = ALU_ADD;
                    6'h22:   alu_op = ALU_SUB;
                    6'h24:   alu_op = ALU_AND;
                    6'h25:   alu_op = ALU_OR;
                    6'h2A:   alu_op = ALU_SLT;
                    default: begin
                        reg_write = 1'b0;
                        uses_rs   = 1'b0;
                        uses_rt   = 1'b0;
                        dest      = '0;
                    end
                endcase
            end
            OP_ADDI: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                uses_rs   = 1'b1;
                dest      = rt;
            end
            OP_LW: begin
                reg_write = 1'b1;
                mem_read  = 1'b1;
                alu_src   = 1'b1;
                uses_rs   = 1'b1;
                dest      = rt;
            end
            OP_SW: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                uses_rs   = 1'b1;
                uses_rt   = 1'b1;
            end
            OP_BEQ: begin
                is_beq  = 1'b1;
                uses_rs = 1'b1;
                uses_rt = 1'b1;
            end
            OP_BNE: begin
                is_bne  = 1'b1;
                uses_rs = 1'b1;
                uses_rt = 1'b1;
            end
            OP_J:    is_j = 1'b1;
            default: ;
        endcase
    end

    // Register reads with same-cycle writeback bypass; r0 is hardwired to zero.
    assign rs_data = (rs == '0) ? '0 :
                     (bus.wbRegWrite && bus.wbDest == rs) ? bus.wbData : regs[rs];
    assign rt_data = (rt == '0) ? '0 :
                     (bus.wbRegWrite && bus.wbDest == rt) ? bus.wbData : regs[rt];

    // Hazards: load result not ready for a consumer, or a branch operand still in flight.
    always_comb begin
        load_use = ifid_valid && bus.exMemRead && (bus.exDest != '0) &&
                   ((uses_rs && rs == bus.exDest) || (uses_rt && rt == bus.exDest));
        branch_hazard = ifid_valid && (is_beq || is_bne) &&
            (((rs != '0) && ((bus.exRegWrite && bus.exDest == rs) ||
                             (bus.memRegWrite && bus.memDest == rs))) ||
             ((rt != '0) && ((bus.exRegWrite && bus.exDest == rt) ||
                             (bus.memRegWrite && bus.memDest == rt))));
        stall = load_use || branch_hazard;
    end

    // Branch/jump resolution in the decode cycle; target wraps modulo 2^WORD_LENGTH.
    always_comb begin
        branch_taken = ifid_valid && !stall &&
                       ((is_beq && rs_data == rt_data) ||
                        (is_bne && rs_data != rt_data) || is_j);
        if (is_j)
            bus.BranchAddress = {ifid_pc4[WORD_LENGTH-1:WORD_LENGTH-4], ifid_instr[25:0], 2'b00};
        else if (is_beq || is_bne)
            bus.BranchAddress = ifid_pc4 + {imm_ext[WORD_LENGTH-3:0], 2'b00};
        else
            bus.BranchAddress = ifid_pc4;
    end

    assign bus.pcEnb       = !stall;
    assign bus.BranchTaken = branch_taken;

    // IF/ID register: hold on stall, squash the wrong-path fetch behind a taken branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_valid <= 1'b0;
            ifid_pc4   <= '0;
            ifid_instr <= '0;
        end else if (!stall) begin
            ifid_valid <= !branch_taken;
            ifid_pc4   <= bus.PCAdder1In;
            ifid_instr <= bus.InstIn;
        end
    end

    // Register file write port; r0 never changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else if (bus.wbRegWrite && bus.wbDest != '0) begin
            regs[bus.wbDest] <= bus.wbData;
        end
    end

    // ID/EX register: bubble on reset, stall or an empty IF/ID slot.
    always_ff @(posedge clk) begin
        if (rst || stall || !ifid_valid) begin
            bus.idExValid    <= 1'b0;
            bus.idExRegWrite <= 1'b0;
            bus.idExMemRead  <= 1'b0;
            bus.idExMemWrite <= 1'b0;
            bus.idExAluSrc   <= 1'b0;
            bus.idExAluOp    <= '0;
            bus.idExRsData   <= '0;
            bus.idExRtData   <= '0;
            bus.idExImm      <= '0;
            bus.idExRs       <= '0;
            bus.idExRt       <= '0;
            bus.idExDest     <= '0;
        end else begin
            bus.idExValid    <= 1'b1;
            bus.idExRegWrite <= reg_write;
            bus.idExMemRead  <= mem_read;
            bus.idExMemWrite <= mem_write;
            bus.idExAluSrc   <= alu_src;
            bus.idExAluOp    <= alu_op;
            bus.idExRsData   <= rs_data;
            bus.idExRtData   <= rt_data;
            bus.idExImm      <= imm_ext;
            bus.idExRs       <= rs;
            bus.idExRt       <= rt;
            bus.idExDest     <= dest;
        end
    end

`ifdef ID_STALL_COUNTER_EN
    logic [31:0] stall_cnt;

    // Count every cycle fetch is held.
    always_ff @(posedge clk) begin
        if (rst)         stall_cnt <= '0;
        else if (stall)  stall_cnt <= stall_cnt + 32'd1;
    end

    assign bus.stallCount = stall_cnt;
`else
    assign bus.stallCount = 32'd0;
`endif
endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios followed by random traffic, all checked
// against a mnemonic-level model of the decode stage.
module tb_id_stage;
    logic clk = 1'b0;
    logic rst;
    id_stage_if bus ();
    id_stage dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef enum int {K_NOP, K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_ADDI, K_LW, K_SW,
                      K_BEQ, K_BNE, K_J} kind_t;

    typedef struct {
        logic        valid, rw, mr, mw, src;
        logic [2:0]  op;
        logic [31:0] rsd, rtd, imm;
        logic [4:0]  rs, rt, dest;
    } idex_t;

    logic [31:0] m_rf [32];
    logic        m_ifv = 1'b0;
    logic [31:0] m_ifpc = '0, m_ifins = '0, m_cnt = '0;
    idex_t       m_idex;

    function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
        return {6'h00, s, t, d, 5'd0, fn};
    endfunction
    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t, input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction
    function automatic logic [31:0] jtype(input logic [25:0] tgt);
        return {6'h02, tgt};
    endfunction

    function automatic kind_t classify(input logic [31:0] ins);
        case (ins[31:26])
            6'h00: case (ins[5:0])
                       6'h20: return K_ADD;
                       6'h22: return K_SUB;
                       6'h24: return K_AND;
                       6'h25: return K_OR;
                       6'h2A: return K_SLT;
                       default: return K_NOP;
                   endcase
            6'h08: return K_ADDI;
            6'h23: return K_LW;
            6'h2B: return K_SW;
            6'h04: return K_BEQ;
            6'h05: return K_BNE;
            6'h02: return K_J;
            default: return K_NOP;
        endcase
    endfunction

    function automatic logic [31:0] rd_val(input logic [4:0] idx);
        if (idx == 0) return 32'd0;
        if (bus.wbRegWrite && bus.wbDest == idx) return bus.wbData;
        return m_rf[idx];
    endfunction

    function automatic bit in_flight(input logic [4:0] s);
        return (s != 0) && ((bus.exRegWrite && bus.exDest == s) || (bus.memRegWrite && bus.memDest == s));
    endfunction

    function automatic idex_t zero_idex();
        idex_t z;
        z.valid = 0; z.rw = 0; z.mr = 0; z.mw = 0; z.src = 0; z.op = 0;
        z.rsd = 0; z.rtd = 0; z.imm = 0; z.rs = 0; z.rt = 0; z.dest = 0;
        return z;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        m_ifv = 0; m_ifpc = 0; m_ifins = 0; m_cnt = 0;
        m_idex = zero_idex();
    endtask

    // One clock: check combinational outputs before the edge, then the registered ones after.
    task automatic step();
        kind_t k;
        logic [4:0] s1, s2;
        bit use1, use2, lu, bs, stall, taken, in_rst, wb_we;
        logic [31:0] v1, v2, target, pc_in, ins_in, wb_d;
        logic [4:0] wb_i;
        idex_t nx;
        #1;
        k  = classify(m_ifins);
        s1 = m_ifins[25:21];
        s2 = m_ifins[20:16];
        use1 = (k != K_NOP) && (k != K_J);
        use2 = k inside {K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_SW, K_BEQ, K_BNE};
        lu = m_ifv && bus.exMemRead && bus.exDest != 0 &&
             ((use1 && s1 == bus.exDest) || (use2 && s2 == bus.exDest));
        bs = m_ifv && (k == K_BEQ || k == K_BNE) && (in_flight(s1) || in_flight(s2));
        stall = lu || bs;
        v1 = rd_val(s1);
        v2 = rd_val(s2);
        taken = m_ifv && !stall && ((k == K_BEQ && v1 == v2) || (k == K_BNE && v1 != v2) || k == K_J);
        if (k == K_J) target = {m_ifpc[31:28], m_ifins[25:0], 2'b00};
        else          target = m_ifpc + {{16{m_ifins[15]}}, m_ifins[15:0]} * 32'd4;
        check("pcEnb", bus.pcEnb, !stall);
        check("BranchTaken", bus.BranchTaken, taken);
        if (taken) check("BranchAddress", bus.BranchAddress, target);

        nx = zero_idex();
        if (m_ifv && !stall) begin
            nx.valid = 1;
            nx.rw  = k inside {K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_ADDI, K_LW};
            nx.mr  = (k == K_LW);
            nx.mw  = (k == K_SW);
            nx.src = k inside {K_ADDI, K_LW, K_SW};
            case (k)
                K_SUB: nx.op = 3'b001;
                K_AND: nx.op = 3'b010;
                K_OR:  nx.op = 3'b011;
                K_SLT: nx.op = 3'b100;
                default: nx.op = 3'b000;
            endcase
            nx.rsd = v1; nx.rtd = v2; nx.rs = s1; nx.rt = s2;
            nx.imm = {{16{m_ifins[15]}}, m_ifins[15:0]};
            if (k inside {K_ADD, K_SUB, K_AND, K_OR, K_SLT}) nx.dest = m_ifins[15:11];
            else if (k == K_ADDI || k == K_LW)               nx.dest = s2;
        end
        in_rst = rst; pc_in = bus.PCAdder1In; ins_in = bus.InstIn;
        wb_we = bus.wbRegWrite; wb_i = bus.wbDest; wb_d = bus.wbData;

        @(posedge clk);
        #1;
        if (in_rst) model_reset();
        else begin
            if (stall) m_cnt++;
            if (wb_we && wb_i != 0) m_rf[wb_i] = wb_d;
            if (!stall) begin
                m_ifpc = pc_in; m_ifins = ins_in; m_ifv = !taken;
            end
            m_idex = nx;
        end
        check("idExValid", bus.idExValid, m_idex.valid);
        check("idExRegWrite", bus.idExRegWrite, m_idex.rw);
        check("idExMemRead", bus.idExMemRead, m_idex.mr);
        check("idExMemWrite", bus.idExMemWrite, m_idex.mw);
        check("idExAluSrc", bus.idExAluSrc, m_idex.src);
        check("idExAluOp", bus.idExAluOp, m_idex.op);
        check("idExRsData", bus.idExRsData, m_idex.rsd);
        check("idExRtData", bus.idExRtData, m_idex.rtd);
        check("idExImm", bus.idExImm, m_idex.imm);
        check("idExRs", bus.idExRs, m_idex.rs);
        check("idExRt", bus.idExRt, m_idex.rt);
        check("idExDest", bus.idExDest, m_idex.dest);
`ifdef ID_STALL_COUNTER_EN
        check("stallCount", bus.stallCount, m_cnt);
`else
        check("stallCount", bus.stallCount, 32'd0);
`endif
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0;
        bus.exMemRead = 0; bus.exRegWrite = 0; bus.exDest = 0;
        bus.memRegWrite = 0; bus.memDest = 0;
        bus.wbRegWrite = 0; bus.wbDest = 0; bus.wbData = 0;
    endtask

    function automatic logic [31:0] rand_ins();
        logic [4:0] a, b, c;
        a = 5'($urandom_range(0, 7));
        b = 5'($urandom_range(0, 7));
        c = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 12))
            0:  return rtype(6'h20, a, b, c);
            1:  return rtype(6'h22, a, b, c);
            2:  return rtype(6'h24, a, b, c);
            3:  return rtype(6'h25, a, b, c);
            4:  return rtype(6'h2A, a, b, c);
            5:  return itype(6'h08, a, b, 16'($urandom));
            6:  return itype(6'h23, a, b, 16'($urandom));
            7:  return itype(6'h2B, a, b, 16'($urandom));
            8:  return itype(6'h04, a, b, 16'($urandom));
            9:  return itype(6'h05, a, b, 16'($urandom));
            10: return jtype(26'($urandom));
            11: return rtype(6'($urandom), a, b, c);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] exp_cnt;
        idle();
        rst = 1;
        bus.PCAdder1In = 0; bus.InstIn = 0;
        @(posedge clk);
        @(negedge clk);
        model_reset();

        // reset state
        rst = 1;
        step(); step();
        check("rst_idExValid", bus.idExValid, 0);
        check("rst_pcEnb", bus.pcEnb, 1);
        check("rst_BranchTaken", bus.BranchTaken, 0);

        // r5 reads zero after reset
        idle();
        bus.PCAdder1In = 32'h4; bus.InstIn = rtype(6'h20, 5'd5, 5'd5, 5'd6);
        step();
        bus.PCAdder1In = 32'h8; bus.InstIn = rtype(6'h20, 5'd3, 5'd3, 5'd4);
        step();
        check("r5_read", bus.idExRsData, 0);

        // WB bypass onto both reads, then r0 write ignored
        bus.wbRegWrite = 1; bus.wbDest = 3; bus.wbData = 32'h1234;
        bus.PCAdder1In = 32'hC; bus.InstIn = rtype(6'h20, 5'd0, 5'd0, 5'd7);
        step();
        check("bypass_rs", bus.idExRsData, 32'h1234);
        check("bypass_rt", bus.idExRtData, 32'h1234);
        bus.wbDest = 0; bus.wbData = 32'h5;
        bus.PCAdder1In = 32'h10; bus.InstIn = 32'h0;
        step();
        check("r0_read", bus.idExRsData, 0);
        idle();

        // load-use stall
        bus.PCAdder1In = 32'h14; bus.InstIn = rtype(6'h20, 5'd2, 5'd1, 5'd5);
        step();
        bus.exMemRead = 1; bus.exRegWrite = 1; bus.exDest = 2;
        bus.PCAdder1In = 32'h18; bus.InstIn = 32'h0;
        #1 check("lu_pcEnb", bus.pcEnb, 0);
        step();
        check("lu_bubble", bus.idExValid, 0);
        idle();
        step();
        check("lu_issue_valid", bus.idExValid, 1);
        check("lu_issue_dest", bus.idExDest, 5);

        // taken beq and flush
        bus.PCAdder1In = 32'h104; bus.InstIn = itype(6'h04, 5'd1, 5'd1, 16'd3);
        step();
        bus.PCAdder1In = 32'h108; bus.InstIn = rtype(6'h20, 5'd1, 5'd1, 5'd9);
        #1 check("beq_taken", bus.BranchTaken, 1);
        check("beq_addr", bus.BranchAddress, 32'h110);
        step();
        check("beq_idex_valid", bus.idExValid, 1);
        check("beq_idex_rw", bus.idExRegWrite, 0);
        step();
        check("flush_bubble", bus.idExValid, 0);

        // jump, untaken bne, branch-operand stall from MEM
        bus.PCAdder1In = 32'hF0000008; bus.InstIn = jtype(26'h40);
        step();
        #1 check("j_taken", bus.BranchTaken, 1);
        check("j_addr", bus.BranchAddress, 32'hF0000100);
        step();
        bus.PCAdder1In = 32'h200; bus.InstIn = itype(6'h05, 5'd1, 5'd1, 16'd8);
        step();
        #1 check("bne_not_taken", bus.BranchTaken, 0);
        bus.InstIn = itype(6'h05, 5'd1, 5'd2, 16'd8);
        step();
        bus.memRegWrite = 1; bus.memDest = 2;
        #1 check("br_mem_stall", bus.pcEnb, 0);
        step();
        idle();
        step();

        // three stall cycles from reset
        rst = 1;
        step();
        idle();
        bus.PCAdder1In = 32'h300; bus.InstIn = rtype(6'h20, 5'd2, 5'd1, 5'd5);
        step();
        bus.exMemRead = 1; bus.exDest = 2;
        step(); step(); step();
`ifdef ID_STALL_COUNTER_EN
        exp_cnt = 32'd3;
`else
        exp_cnt = 32'd0;
`endif
        check("stall_count_3", bus.stallCount, exp_cnt);
        idle();
        step();

        // random traffic
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            bus.PCAdder1In = {$urandom, 2'b00} >> 0;
            bus.InstIn = rand_ins();
            bus.exMemRead = ($urandom_range(0, 3) == 0);
            bus.exRegWrite = $urandom_range(0, 1);
            bus.exDest = 5'($urandom_range(0, 7));
            bus.memRegWrite = $urandom_range(0, 1);
            bus.memDest = 5'($urandom_range(0, 7));
            bus.wbRegWrite = $urandom_range(0, 1);
            bus.wbDest = 5'($urandom_range(0, 7));
            bus.wbData = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
